// File: rtl/truth_table_sweep_3inputs_pkg.sv
// Shared types and helpers for the 3-input truth-table sweep stage.
// Holds the FSM state encoding, vector count and index-to-pin mapping.
package truth_table_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned NUM_VECTORS = 8;
    localparam logic [2:0]  LAST_IDX    = 3'(NUM_VECTORS - 1);

    typedef struct packed {
        logic a;
        logic b;
        logic c;
    } abc_t;

    // Vector index i maps to {a,b,c} = i, a being the MSB.
    function automatic abc_t vec_to_abc(input logic [2:0] idx);
        abc_t v;
        v.a = idx[2];
        v.b = idx[1];
        v.c = idx[0];
        return v;
    endfunction

endpackage

// File: rtl/truth_table_sweep_3inputs_hold.sv
// Per-vector hold timer: counts clocks while enabled and flags the final
// hold cycle, wrapping to zero so the next vector starts a fresh window.
module sweep_hold_counter #(
    parameter int unsigned HOLD_CYCLES = 100,
    parameter int unsigned CNT_W       = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic last
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(HOLD_CYCLES - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= last ? '0 : count + CNT_W'(1);
        end
    end

    assign last = (count == LAST_CNT);

endmodule

// File: rtl/truth_table_sweep_3inputs.sv
// Clocked sweep of all eight {a,b,c} vectors into a truth-table block,
// capturing y per vector and comparing the result against a golden word.
module truth_table_sweep_3inputs
    import truth_table_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 100,
    parameter int unsigned CNT_W       = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] expected,
    input  logic       y,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic [7:0] table_out,
    output logic       pass
);

    state_t     state, state_nx;
    logic [2:0] idx;
    abc_t       abc_q;
    logic       hold_last;
    logic       hold_clear;
    logic       hold_en;

    // Counter sits at zero outside RUN so every sweep opens a full window.
    assign hold_clear = (state != RUN);
    assign hold_en    = (state == RUN);

    sweep_hold_counter #(
        .HOLD_CYCLES (HOLD_CYCLES),
        .CNT_W       (CNT_W)
    ) u_hold (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (hold_clear),
        .enable (hold_en),
        .last   (hold_last)
    );

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (start) state_nx = RUN;
            RUN:  if (hold_last && idx == LAST_IDX) state_nx = DONE;
            DONE: if (start) state_nx = RUN;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            abc_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            table_out <= '0;
        end else begin
            state <= state_nx;
            busy  <= (state_nx == RUN);
            done  <= (state_nx == DONE);
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        idx       <= '0;
                        abc_q     <= vec_to_abc(3'd0);
                        table_out <= '0;
                    end
                end
                RUN: begin
                    if (hold_last) begin
                        table_out[idx] <= y;
                        // Final vector stays on the pins while DONE.
                        if (idx != LAST_IDX) begin
                            idx   <= idx + 3'd1;
                            abc_q <= vec_to_abc(idx + 3'd1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign {a, b, c} = abc_q;
    assign pass      = done && (table_out == expected);

endmodule

// File: tb/tb_truth_table_sweep_3inputs.sv
// Directed bench for the truth-table sweep: two instances (hold 1 and 4)
// driven by a behavioural truth-table model with hand-derived golden words.
module tb_truth_table_sweep_3inputs;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_r;
    logic       sel;
    logic       glitch;
    logic [7:0] exp_w;
    int         mode;

    logic       start1, y1, a1, b1, c1, busy1, done1, pass1;
    logic [7:0] tab1;
    logic       start4, y4, a4, b4, c4, busy4, done4, pass4;
    logic [7:0] tab4;

    logic [2:0] abc_o;
    logic       busy_o, done_o, pass_o;
    logic [7:0] tab_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // mode 0 = majority, 1 = AND, 2 = XOR
    function automatic logic fmodel(input int m, input logic [2:0] v);
        case (m)
            0:       return (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
            1:       return v[2] & v[1] & v[0];
            default: return v[2] ^ v[1] ^ v[0];
        endcase
    endfunction

    assign start1 = start_r & ~sel;
    assign start4 = start_r & sel;
    assign y1     = fmodel(mode, {a1, b1, c1}) ^ (glitch & ~sel);
    assign y4     = fmodel(mode, {a4, b4, c4}) ^ (glitch & sel);

    assign abc_o  = sel ? {a4, b4, c4} : {a1, b1, c1};
    assign busy_o = sel ? busy4 : busy1;
    assign done_o = sel ? done4 : done1;
    assign pass_o = sel ? pass4 : pass1;
    assign tab_o  = sel ? tab4  : tab1;

    truth_table_sweep_3inputs #(
        .HOLD_CYCLES (1),
        .CNT_W       (16)
    ) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start1),
        .expected  (exp_w),
        .y         (y1),
        .a         (a1),
        .b         (b1),
        .c         (c1),
        .busy      (busy1),
        .done      (done1),
        .table_out (tab1),
        .pass      (pass1)
    );

    truth_table_sweep_3inputs #(
        .HOLD_CYCLES (4),
        .CNT_W       (16)
    ) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start4),
        .expected  (exp_w),
        .y         (y4),
        .a         (a4),
        .b         (b4),
        .c         (c4),
        .busy      (busy4),
        .done      (done4),
        .table_out (tab4),
        .pass      (pass4)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, got, want, $time);
        end
    endtask

    // Called at a falling edge; launches a sweep on the selected instance.
    task automatic run_sweep(input int h, input logic [7:0] want_tab, input logic want_pass,
                             input bit extra_starts, input bit glitchy);
        start_r = 1'b1;
        @(negedge clk);
        start_r = 1'b0;
        for (int k = 0; k < 8 * h; k++) begin
            check_eq("abc", 32'(abc_o), 32'(k / h));
            check_eq("busy_run", 32'(busy_o), 32'd1);
            check_eq("done_run", 32'(done_o), 32'd0);
            if (k == 0) check_eq("tab_clear", 32'(tab_o), 32'd0);
            glitch  = glitchy && (k % h < 2) && ((k / h) % 2 == 0);
            start_r = extra_starts && (k == 3 || k == 5);
            @(negedge clk);
        end
        glitch  = 1'b0;
        start_r = 1'b0;
        check_eq("done_end", 32'(done_o), 32'd1);
        check_eq("busy_end", 32'(busy_o), 32'd0);
        check_eq("abc_end",  32'(abc_o), 32'd7);
        check_eq("table",    32'(tab_o), 32'(want_tab));
        check_eq("pass",     32'(pass_o), 32'(want_pass));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen_done;
        rst_n   = 1'b0;
        start_r = 1'b1;
        sel     = 1'b0;
        glitch  = 1'b0;
        mode    = 0;
        exp_w   = 8'hE8;
        repeat (2) @(negedge clk);
        check_eq("rst_abc1",  32'({a1, b1, c1}), 32'd0);
        check_eq("rst_busy1", 32'(busy1), 32'd0);
        check_eq("rst_done1", 32'(done1), 32'd0);
        check_eq("rst_tab1",  32'(tab1), 32'd0);
        check_eq("rst_pass1", 32'(pass1), 32'd0);
        check_eq("rst_abc4",  32'({a4, b4, c4}), 32'd0);
        check_eq("rst_busy4", 32'(busy4), 32'd0);
        check_eq("rst_done4", 32'(done4), 32'd0);
        rst_n   = 1'b1;
        start_r = 1'b0;
        @(negedge clk);

        // Majority, hold 1, matching golden word
        run_sweep(1, 8'hE8, 1'b1, 1'b0, 1'b0);

        // Restart from DONE with AND model
        mode  = 1;
        exp_w = 8'h80;
        run_sweep(1, 8'h80, 1'b1, 1'b0, 1'b0);

        // Majority against a wrong golden word, then fix it live
        mode  = 0;
        exp_w = 8'hE9;
        run_sweep(1, 8'hE8, 1'b0, 1'b0, 1'b0);
        exp_w = 8'hE8;
        #1;
        check_eq("pass_live", 32'(pass1), 32'd1);
        @(negedge clk);

        // XOR, hold 4, with early-window glitches on y
        sel   = 1'b1;
        mode  = 2;
        exp_w = 8'h96;
        run_sweep(4, 8'h96, 1'b1, 1'b0, 1'b1);

        // Stray start pulses mid-sweep are ignored
        sel   = 1'b0;
        mode  = 0;
        exp_w = 8'hE8;
        run_sweep(1, 8'hE8, 1'b1, 1'b1, 1'b0);

        // Reset abort at vector 4
        start_r = 1'b1;
        @(negedge clk);
        start_r = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("abort_vec", 32'({a1, b1, c1}), 32'd4);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("abort_abc",  32'({a1, b1, c1}), 32'd0);
        check_eq("abort_busy", 32'(busy1), 32'd0);
        check_eq("abort_done", 32'(done1), 32'd0);
        check_eq("abort_tab",  32'(tab1), 32'd0);
        check_eq("abort_pass", 32'(pass1), 32'd0);
        seen_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done1 || busy1) seen_done = 1'b1;
        end
        check_eq("abort_idle", 32'(seen_done), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
